// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: decoder enable bit positions,
// trap causes and issue FSM states.
package issue_ctrl_pkg;

    localparam int unsigned EnRs1   = 0;
    localparam int unsigned EnRs2   = 1;
    localparam int unsigned EnRd    = 2;
    localparam int unsigned EnMread = 3;
    localparam int unsigned EnMwrite = 4;

    typedef enum logic [1:0] {
        CauseNone    = 2'b00,
        CauseIllegal = 2'b01,
        CauseEcall   = 2'b10,
        CauseEbreak  = 2'b11
    } trap_cause_e;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StTrap,
        StHalt
    } issue_state_e;

    // Illegal encoding outranks ebreak, which outranks ecall.
    function automatic trap_cause_e decode_cause(input logic illegal, input logic [1:0] env);
        if (illegal) begin
            return CauseIllegal;
        end else if (env[1]) begin
            return CauseEbreak;
        end else if (env[0]) begin
            return CauseEcall;
        end
        return CauseNone;
    endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Register scoreboard: one busy bit per architectural register, x0 never busy.
module issue_ctrl_scoreboard #(
    parameter int unsigned RF_SIZE = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_en,
    input  logic [RF_SIZE-1:0]        set_idx,
    input  logic                      clr_en,
    input  logic [RF_SIZE-1:0]        clr_idx,
    input  logic                      flush,
    output logic [(2**RF_SIZE)-1:0]   busy
);

    logic [(2**RF_SIZE)-1:0] busy_d, busy_q;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        // A new issue to the register retiring this cycle must stay busy.
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: scoreboard-based hazard stall, in-flight limit,
// and a drain-then-trap sequence for decoder-reported exceptions.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int unsigned RF_SIZE      = 5,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid_i,
    output logic                         id_ready_o,
    input  logic [4:0]                   enable_i,
    input  logic [2:0][RF_SIZE-1:0]      regi_i,
    input  logic                         decode_error_i,
    input  logic [1:0]                   env_exception_i,
    output logic                         ex_valid_o,
    input  logic                         ex_ready_i,
    input  logic                         wb_valid_i,
    input  logic                         wb_we_i,
    input  logic [RF_SIZE-1:0]           wb_rd_i,
    input  logic                         flush_i,
    output logic                         trap_o,
    output logic [1:0]                   trap_cause_o,
    output logic [(2**RF_SIZE)-1:0]      busy_o,
    output logic [CNT_W-1:0]             inflight_o
);

    issue_state_e state_d, state_q;
    trap_cause_e  cause_d, cause_q;
    logic [CNT_W-1:0] inflight_d, inflight_q;
    logic [(2**RF_SIZE)-1:0] busy;

    logic exc, hazard, full, fire, wb_dec;
    logic [RF_SIZE-1:0] rs1, rs2, rd;

    // Memory enables do not affect issue; only the register enables gate hazards.
    logic unused_mem_en;
    assign unused_mem_en = ^enable_i[EnMwrite:EnMread];

    assign rs1 = regi_i[EnRs1];
    assign rs2 = regi_i[EnRs2];
    assign rd  = regi_i[EnRd];

    assign exc    = decode_error_i | (|env_exception_i);
    assign hazard = (enable_i[EnRs1] & busy[rs1]) |
                    (enable_i[EnRs2] & busy[rs2]) |
                    (enable_i[EnRd]  & busy[rd]);
    assign full   = (inflight_q == CNT_W'(MAX_INFLIGHT));

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        ex_valid_o = 1'b0;
        id_ready_o = 1'b0;
        trap_o     = 1'b0;
        fire       = 1'b0;
        unique case (state_q)
            StRun: begin
                if (flush_i) begin
                    // Nothing is accepted while the pipeline is being killed.
                end else if (id_valid_i && exc) begin
                    id_ready_o = 1'b1;
                    cause_d    = decode_cause(decode_error_i, env_exception_i);
                    state_d    = StDrain;
                end else begin
                    ex_valid_o = id_valid_i & ~hazard & ~full;
                    fire       = ex_valid_o & ex_ready_i;
                    id_ready_o = fire;
                end
            end
            StDrain: begin
                if (inflight_q == '0) begin
                    state_d = StTrap;
                end
            end
            StTrap: begin
                trap_o  = 1'b1;
                state_d = StHalt;
            end
            StHalt: begin
            end
            default: state_d = StRun;
        endcase
        if (flush_i) begin
            state_d = StRun;
            cause_d = CauseNone;
        end
    end

    assign trap_cause_o = (state_q == StTrap) ? cause_q : CauseNone;

    // Retire at zero outstanding is dropped so the counter never wraps.
    assign wb_dec = wb_valid_i && (inflight_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        if (fire && !wb_dec) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!fire && wb_dec) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
        if (flush_i) begin
            inflight_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            cause_q    <= CauseNone;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            inflight_q <= inflight_d;
        end
    end

    issue_ctrl_scoreboard #(
        .RF_SIZE (RF_SIZE)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (fire & enable_i[EnRd]),
        .set_idx (rd),
        .clr_en  (wb_valid_i & wb_we_i),
        .clr_idx (wb_rd_i),
        .flush   (flush_i),
        .busy    (busy)
    );

    assign busy_o     = busy;
    assign inflight_o = inflight_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl with hand-computed expectations.
module tb_issue_ctrl;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid_i;
    logic            id_ready_o;
    logic [4:0]      enable_i;
    logic [2:0][4:0] regi_i;
    logic            decode_error_i;
    logic [1:0]      env_exception_i;
    logic            ex_valid_o;
    logic            ex_ready_i;
    logic            wb_valid_i;
    logic            wb_we_i;
    logic [4:0]      wb_rd_i;
    logic            flush_i;
    logic            trap_o;
    logic [1:0]      trap_cause_o;
    logic [31:0]     busy_o;
    logic [2:0]      inflight_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Enable encodings: RS1=bit0, RS2=bit1, RD=bit2, MWRITE=bit4
    localparam logic [4:0] EnAlu   = 5'b00111;
    localparam logic [4:0] EnRdOnly = 5'b00100;
    localparam logic [4:0] EnRs1Only = 5'b00001;
    localparam logic [4:0] EnReads = 5'b00011;
    localparam logic [4:0] EnStore = 5'b10011;

    issue_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid_i      (id_valid_i),
        .id_ready_o      (id_ready_o),
        .enable_i        (enable_i),
        .regi_i          (regi_i),
        .decode_error_i  (decode_error_i),
        .env_exception_i (env_exception_i),
        .ex_valid_o      (ex_valid_o),
        .ex_ready_i      (ex_ready_i),
        .wb_valid_i      (wb_valid_i),
        .wb_we_i         (wb_we_i),
        .wb_rd_i         (wb_rd_i),
        .flush_i         (flush_i),
        .trap_o          (trap_o),
        .trap_cause_o    (trap_cause_o),
        .busy_o          (busy_o),
        .inflight_o      (inflight_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        id_valid_i      = 1'b0;
        enable_i        = '0;
        regi_i          = '0;
        decode_error_i  = 1'b0;
        env_exception_i = 2'b00;
        wb_valid_i      = 1'b0;
        wb_we_i         = 1'b0;
        wb_rd_i         = '0;
        flush_i         = 1'b0;
    endtask

    task automatic insn(input logic [4:0] en, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd);
        id_valid_i      = 1'b1;
        enable_i        = en;
        regi_i[0]       = r1;
        regi_i[1]       = r2;
        regi_i[2]       = rd;
        decode_error_i  = 1'b0;
        env_exception_i = 2'b00;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd);
        wb_valid_i = 1'b1;
        wb_we_i    = we;
        wb_rd_i    = rd;
    endtask

    task automatic do_flush();
        idle();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        idle();
        ex_ready_i = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        #1;
        check("rst_busy", busy_o, 32'h0);
        check("rst_inflight", 32'(inflight_o), 0);
        check("rst_trap", 32'(trap_o), 0);
        check("rst_cause", 32'(trap_cause_o), 0);
        check("rst_ex_valid", 32'(ex_valid_o), 0);
        check("rst_id_ready", 32'(id_ready_o), 0);
        rst = 1'b0;
        tick();

        // Back-to-back independent ALU ops to x1, x2, x3.
        for (int i = 1; i <= 3; i++) begin
            insn(EnAlu, 5'd0, 5'd0, 5'(i));
            #1;
            check("b2b_ex_valid", 32'(ex_valid_o), 1);
            tick();
        end
        idle();
        #1;
        check("b2b_busy", busy_o, 32'h0000_000E);
        check("b2b_inflight", 32'(inflight_o), 3);
        do_flush();

        // RAW on x5: stall until the cycle after writeback.
        insn(EnRdOnly, 5'd0, 5'd0, 5'd5);
        tick();
        insn(EnRs1Only, 5'd5, 5'd0, 5'd0);
        #1;
        check("raw_stall0", 32'(ex_valid_o), 0);
        tick();
        check("raw_stall1", 32'(ex_valid_o), 0);
        wb(1'b1, 5'd5);
        #1;
        check("raw_no_bypass", 32'(ex_valid_o), 0);
        tick();
        wb_valid_i = 1'b0;
        #1;
        check("raw_release", 32'(ex_valid_o), 1);
        check("raw_busy_clear", busy_o, 32'h0);
        tick();
        idle();
        #1;
        check("raw_inflight", 32'(inflight_o), 1);
        do_flush();

        // Writes to x0 never mark busy.
        insn(EnRdOnly, 5'd0, 5'd0, 5'd0);
        tick();
        insn(EnReads, 5'd0, 5'd0, 5'd0);
        #1;
        check("x0_busy", busy_o, 32'h0);
        check("x0_read_issue", 32'(ex_valid_o), 1);
        tick();
        idle();
        #1;
        check("x0_inflight", 32'(inflight_o), 2);
        do_flush();

        // Fill the in-flight window with stores.
        for (int i = 0; i < 4; i++) begin
            insn(EnStore, 5'd0, 5'd0, 5'd0);
            tick();
        end
        #1;
        check("full_inflight", 32'(inflight_o), 4);
        check("full_stall", 32'(ex_valid_o), 0);
        wb(1'b0, 5'd0);
        #1;
        check("full_stall_wb", 32'(ex_valid_o), 0);
        tick();
        check("full_after_wb", 32'(inflight_o), 3);
        #1;
        check("fire_wb_ex_valid", 32'(ex_valid_o), 1);
        tick();
        check("fire_wb_hold", 32'(inflight_o), 3);
        wb_valid_i = 1'b0;
        tick();
        check("refill", 32'(inflight_o), 4);
        do_flush();

        // Ebreak with two in flight: drain, trap, halt.
        for (int i = 0; i < 2; i++) begin
            insn(EnStore, 5'd0, 5'd0, 5'd0);
            tick();
        end
        insn(EnAlu, 5'd0, 5'd0, 5'd1);
        env_exception_i = 2'b10;
        #1;
        check("exc_id_ready", 32'(id_ready_o), 1);
        check("exc_ex_valid", 32'(ex_valid_o), 0);
        tick();
        insn(EnAlu, 5'd0, 5'd0, 5'd1);
        #1;
        check("drain_id_ready", 32'(id_ready_o), 0);
        check("drain_ex_valid", 32'(ex_valid_o), 0);
        wb(1'b0, 5'd0);
        tick();
        check("drain_trap0", 32'(trap_o), 0);
        tick();
        wb_valid_i = 1'b0;
        check("drain_inflight0", 32'(inflight_o), 0);
        check("drain_trap1", 32'(trap_o), 0);
        tick();
        check("trap_pulse", 32'(trap_o), 1);
        check("trap_cause_ebreak", 32'(trap_cause_o), 3);
        tick();
        check("halt_trap", 32'(trap_o), 0);
        check("halt_cause", 32'(trap_cause_o), 0);
        check("halt_id_ready", 32'(id_ready_o), 0);
        tick();
        check("halt_id_ready2", 32'(id_ready_o), 0);
        do_flush();
        insn(EnAlu, 5'd0, 5'd0, 5'd2);
        #1;
        check("post_flush_accept", 32'(id_ready_o), 1);
        tick();
        do_flush();

        // Illegal outranks ecall; trap exactly 2 edges after acceptance.
        insn(EnAlu, 5'd0, 5'd0, 5'd1);
        decode_error_i  = 1'b1;
        env_exception_i = 2'b01;
        tick();
        idle();
        #1;
        check("ill_edge1_trap", 32'(trap_o), 0);
        tick();
        check("ill_trap", 32'(trap_o), 1);
        check("ill_cause", 32'(trap_cause_o), 1);
        do_flush();

        // Flush wins over a simultaneous fire.
        insn(EnRdOnly, 5'd0, 5'd0, 5'd9);
        tick();
        insn(EnRdOnly, 5'd0, 5'd0, 5'd7);
        flush_i = 1'b1;
        #1;
        check("flush_ex_valid", 32'(ex_valid_o), 0);
        check("flush_id_ready", 32'(id_ready_o), 0);
        tick();
        flush_i = 1'b0;
        idle();
        #1;
        check("flush_busy", busy_o, 32'h0);
        check("flush_inflight", 32'(inflight_o), 0);

        // Reset mid-drain returns to RUN with state cleared.
        insn(EnRdOnly, 5'd0, 5'd0, 5'd4);
        tick();
        insn(EnAlu, 5'd0, 5'd0, 5'd1);
        env_exception_i = 2'b01;
        tick();
        idle();
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy_o, 32'h0);
        check("rst_mid_inflight", 32'(inflight_o), 0);
        tick();
        rst = 1'b0;
        tick();
        insn(EnAlu, 5'd0, 5'd0, 5'd4);
        #1;
        check("rst_mid_run", 32'(id_ready_o), 1);
        tick();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
